// File: rtl/ima_stream_tx.sv
// ima_stream_tx: reads NUM_FRAMES raster images from a synchronous frame
// buffer and streams them to the conv layer with frame/line markers.
// A pixel issued to the RAM in cycle N appears on ena_out/ima_out in N+2.
module ima_stream_tx #(
    parameter int IMA        = 8,
    parameter int W          = 32,
    parameter int H          = 32,
    parameter int NUM_FRAMES = 5,
    parameter int GAP_CYC    = 4,
    parameter int ADDR_W     = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              hold,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [IMA-1:0]    rd_data,
    output logic [IMA-1:0]    ima_out,
    output logic              ena_out,
    output logic              frame_start_out,
    output logic              line_start_out,
    output logic              frame_end_out,
    output logic              frame_start_dim_out,
    output logic              frame_end_dim_out,
    output logic              busy,
    output logic              done
);

    localparam int COL_W = (W > 1) ? $clog2(W) : 1;
    localparam int ROW_W = (H > 1) ? $clog2(H) : 1;
    localparam int FRM_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_GAP   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [COL_W-1:0]    r_col;
    logic [ROW_W-1:0]    r_row;
    logic [FRM_W-1:0]    r_frm;
    logic [GAP_W-1:0]    r_gap;
    logic                r_drain;
    logic                r_busy;
    logic                r_done;

    // Marker order everywhere: {frame_start, line_start, frame_end, fs_dim, fe_dim}
    logic                r_s1_vld;
    logic [4:0]          r_s1_mk;
    logic                r_ena;
    logic [4:0]          r_mk;
    logic [IMA-1:0]      r_ima;

    logic                w_issue;
    logic                w_col_last;
    logic                w_row_last;
    logic                w_frm_last;
    logic                w_line_start;
    logic                w_frame_start;
    logic                w_frame_end;
    logic [4:0]          w_mk;

    assign w_issue       = (r_state == S_RUN) && !hold;
    assign w_col_last    = (r_col == COL_W'(W - 1));
    assign w_row_last    = (r_row == ROW_W'(H - 1));
    assign w_frm_last    = (r_frm == FRM_W'(NUM_FRAMES - 1));
    assign w_line_start  = (r_col == COL_W'(0));
    assign w_frame_start = w_line_start && (r_row == ROW_W'(0));
    assign w_frame_end   = w_col_last && w_row_last;
    assign w_mk          = {w_frame_start, w_line_start, w_frame_end,
                            w_frame_start && (r_frm == FRM_W'(0)),
                            w_frame_end && w_frm_last};

    // Sequencer: run state, raster counters and the running read address.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_frm   <= '0;
            r_gap   <= '0;
            r_drain <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= S_RUN;
                        r_addr  <= base_addr;
                        r_col   <= '0;
                        r_row   <= '0;
                        r_frm   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_issue) begin
                        // Frames are contiguous, so the address simply counts up.
                        r_addr <= r_addr + ADDR_W'(1);
                        if (w_col_last) begin
                            r_col <= '0;
                            if (w_row_last) begin
                                r_row <= '0;
                                if (w_frm_last) begin
                                    r_frm   <= '0;
                                    r_drain <= 1'b0;
                                    r_state <= S_DRAIN;
                                end else begin
                                    r_frm <= r_frm + FRM_W'(1);
                                    r_gap <= '0;
                                    if (GAP_CYC == 0) begin
                                        r_state <= S_RUN;
                                    end else begin
                                        r_state <= S_GAP;
                                    end
                                end
                            end else begin
                                r_row <= r_row + ROW_W'(1);
                            end
                        end else begin
                            r_col <= r_col + COL_W'(1);
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap == GAP_W'(GAP_CYC - 1)) begin
                        r_state <= S_RUN;
                    end else begin
                        r_gap <= r_gap + GAP_W'(1);
                    end
                end
                S_DRAIN: begin
                    // Two cycles let the last issued pixel reach ena_out.
                    if (r_drain) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Two-stage output pipeline keeping markers aligned with their pixel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_s1_mk  <= 5'd0;
            r_ena    <= 1'b0;
            r_mk     <= 5'd0;
            r_ima    <= '0;
        end else begin
            r_s1_vld <= w_issue;
            r_s1_mk  <= w_issue ? w_mk : 5'd0;
            r_ena    <= r_s1_vld;
            r_mk     <= r_s1_vld ? r_s1_mk : 5'd0;
            if (r_s1_vld) begin
                r_ima <= rd_data;
            end else begin
                r_ima <= r_ima;
            end
        end
    end

    assign rd_en               = w_issue;
    assign rd_addr             = r_addr;
    assign ima_out             = r_ima;
    assign ena_out             = r_ena;
    assign frame_start_out     = r_mk[4];
    assign line_start_out      = r_mk[3];
    assign frame_end_out       = r_mk[2];
    assign frame_start_dim_out = r_mk[1];
    assign frame_end_dim_out   = r_mk[0];
    assign busy                = r_busy;
    assign done                = r_done;

endmodule

// File: tb/tb_ima_stream_tx.sv
// Scoreboard bench for ima_stream_tx: three instances (gap 3, gap 0, 1x1x1),
// expected reads/pixels/done pushed at stimulus time, popped by a monitor.
module tb_ima_stream_tx;

    localparam int AW = 13;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          start;
    logic          hold;
    logic [AW-1:0] base;
    int            sel;
    int            cyc = 0;
    logic          mon_on = 1'b0;

    logic          rd_en_v   [3];
    logic [AW-1:0] rd_addr_v [3];
    logic [7:0]    rd_data_v [3];
    logic [7:0]    ima_v     [3];
    logic          ena_v     [3];
    logic          fs_v      [3];
    logic          ls_v      [3];
    logic          fe_v      [3];
    logic          fsd_v     [3];
    logic          fed_v     [3];
    logic          busy_v    [3];
    logic          done_v    [3];

    ima_stream_tx #(.IMA(8), .W(4), .H(2), .NUM_FRAMES(2), .GAP_CYC(3), .ADDR_W(AW)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 0), .base_addr(base),
        .hold(hold && sel == 0), .rd_en(rd_en_v[0]), .rd_addr(rd_addr_v[0]),
        .rd_data(rd_data_v[0]), .ima_out(ima_v[0]), .ena_out(ena_v[0]),
        .frame_start_out(fs_v[0]), .line_start_out(ls_v[0]), .frame_end_out(fe_v[0]),
        .frame_start_dim_out(fsd_v[0]), .frame_end_dim_out(fed_v[0]),
        .busy(busy_v[0]), .done(done_v[0]));

    ima_stream_tx #(.IMA(8), .W(4), .H(2), .NUM_FRAMES(2), .GAP_CYC(0), .ADDR_W(AW)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 1), .base_addr(base),
        .hold(hold && sel == 1), .rd_en(rd_en_v[1]), .rd_addr(rd_addr_v[1]),
        .rd_data(rd_data_v[1]), .ima_out(ima_v[1]), .ena_out(ena_v[1]),
        .frame_start_out(fs_v[1]), .line_start_out(ls_v[1]), .frame_end_out(fe_v[1]),
        .frame_start_dim_out(fsd_v[1]), .frame_end_dim_out(fed_v[1]),
        .busy(busy_v[1]), .done(done_v[1]));

    ima_stream_tx #(.IMA(8), .W(1), .H(1), .NUM_FRAMES(1), .GAP_CYC(2), .ADDR_W(AW)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 2), .base_addr(base),
        .hold(hold && sel == 2), .rd_en(rd_en_v[2]), .rd_addr(rd_addr_v[2]),
        .rd_data(rd_data_v[2]), .ima_out(ima_v[2]), .ena_out(ena_v[2]),
        .frame_start_out(fs_v[2]), .line_start_out(ls_v[2]), .frame_end_out(fe_v[2]),
        .frame_start_dim_out(fsd_v[2]), .frame_end_dim_out(fed_v[2]),
        .busy(busy_v[2]), .done(done_v[2]));

    // Frame buffer models: RAM[a] = a (low byte), one-cycle read latency.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rd_en_v[k]) rd_data_v[k] <= rd_addr_v[k][7:0];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    logic          m_rd_en, m_ena, m_busy, m_done;
    logic [AW-1:0] m_rd_addr;
    logic [7:0]    m_ima;
    logic [4:0]    m_mk;
    assign m_rd_en   = rd_en_v[sel];
    assign m_rd_addr = rd_addr_v[sel];
    assign m_ena     = ena_v[sel];
    assign m_ima     = ima_v[sel];
    assign m_busy    = busy_v[sel];
    assign m_done    = done_v[sel];
    assign m_mk      = {fs_v[sel], ls_v[sel], fe_v[sel], fsd_v[sel], fed_v[sel]};

    typedef struct {
        int          cyc;
        logic [31:0] val;
    } exp_t;

    exp_t rd_q[$];
    exp_t out_q[$];
    int   done_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic extra(input string name, input logic [31:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: unexpected output %0h with nothing expected (cycle %0d)", name, act, cyc);
    endtask

    // Reference model: issue schedule with hold window and gaps, cut off at 'cut'.
    task automatic model(input int t0, input int b, input int s, input int hs, input int he,
                         input int cut, output int done_rel);
        int w, h, nf, gap, c, p;
        logic fs, ls, fe, fsd, fed;
        logic [7:0] pv;
        exp_t e;
        w   = (s == 2) ? 1 : 4;
        h   = (s == 2) ? 1 : 2;
        nf  = (s == 2) ? 1 : 2;
        gap = (s == 0) ? 3 : (s == 1) ? 0 : 2;
        c = 1;
        p = b;
        for (int f = 0; f < nf; f++) begin
            for (int r = 0; r < h; r++) begin
                for (int col = 0; col < w; col++) begin
                    while (c >= hs && c <= he) c++;
                    ls  = (col == 0);
                    fs  = (col == 0) && (r == 0);
                    fe  = (col == w - 1) && (r == h - 1);
                    fsd = fs && (f == 0);
                    fed = fe && (f == nf - 1);
                    pv  = p[7:0];
                    if (c <= cut) begin
                        e.cyc = t0 + c; e.val = 32'(p); rd_q.push_back(e);
                    end
                    if (c + 2 <= cut) begin
                        e.cyc = t0 + c + 2; e.val = {19'd0, pv, fs, ls, fe, fsd, fed};
                        out_q.push_back(e);
                    end
                    c++;
                    p++;
                end
            end
            if (f != nf - 1) c += gap;
        end
        done_rel = c + 2;
        if (done_rel <= cut) done_q.push_back(t0 + done_rel);
    endtask

    // Monitor: pops scoreboard entries whenever the DUT presents a read, pixel or done.
    initial begin
        exp_t e;
        int   d;
        forever begin
            @(negedge clk);
            #1;
            if (mon_on) begin
                if (m_rd_en) begin
                    if (rd_q.size() == 0) extra("rd_extra", 32'(m_rd_addr));
                    else begin
                        e = rd_q.pop_front();
                        check("rd_cycle", cyc, e.cyc);
                        check("rd_addr", 32'(m_rd_addr), e.val);
                    end
                end
                if (m_ena) begin
                    if (out_q.size() == 0) extra("pix_extra", {19'd0, m_ima, m_mk});
                    else begin
                        e = out_q.pop_front();
                        check("pix_cycle", cyc, e.cyc);
                        check("pix_data_markers", {19'd0, m_ima, m_mk}, e.val);
                    end
                end else begin
                    check("idle_markers", 32'(m_mk), 32'd0);
                end
                if (m_done) begin
                    if (done_q.size() == 0) extra("done_extra", 32'd1);
                    else begin
                        d = done_q.pop_front();
                        check("done_cycle", cyc, d);
                    end
                end
            end
        end
    end

    // One scenario: start at rel 0, optional hold window, second start, reset.
    task automatic run_scn(input int s, input int b, input int hs, input int he,
                           input int restart, input int rstc, input int ncyc);
        int t0, dr, dr2;
        @(negedge clk);
        sel  = s;
        base = AW'(b);
        t0   = cyc;
        if (rstc >= 0) begin
            model(t0, b, s, hs, he, rstc, dr);
            model(t0 + restart, b, s, 0, -1, 100000, dr2);
        end else begin
            model(t0, b, s, hs, he, 100000, dr);
        end
        for (int rel = 0; rel < ncyc; rel++) begin
            if (rel > 0) @(negedge clk);
            start = (rel == 0) || (rel == restart);
            hold  = (rel >= hs) && (rel <= he);
            rst_n = (rel != rstc);
            #1;
            if (rstc < 0) begin
                check("busy", 32'(m_busy), 32'((rel >= 1) && (rel <= dr)));
            end else if (rel == rstc + 1) begin
                check("rst_ena", 32'(m_ena), 32'd0);
                check("rst_ima", 32'(m_ima), 32'd0);
                check("rst_markers", 32'(m_mk), 32'd0);
                check("rst_busy", 32'(m_busy), 32'd0);
                check("rst_done", 32'(m_done), 32'd0);
                check("rst_rd_en", 32'(m_rd_en), 32'd0);
            end
        end
        @(negedge clk);
        start = 1'b0;
        hold  = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        hold  = 1'b0;
        base  = '0;
        sel   = 0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_ena", 32'(m_ena), 32'd0);
        check("reset_ima", 32'(m_ima), 32'd0);
        check("reset_busy", 32'(m_busy), 32'd0);
        check("reset_done", 32'(m_done), 32'd0);
        check("reset_rd_en", 32'(m_rd_en), 32'd0);
        check("reset_markers", 32'(m_mk), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_on = 1'b1;
        repeat (2) @(negedge clk);

        run_scn(0, 16, 0, -1, -1, -1, 28);   // plain run, gap 3
        run_scn(0, 16, 4, 6, -1, -1, 30);    // hold in cycles 4-6
        run_scn(0, 16, 0, -1, 5, -1, 28);    // ignored start at cycle 5
        run_scn(0, 16, 0, -1, 10, 6, 40);    // reset at 6, fresh start at 10
        run_scn(1, 16, 0, -1, -1, -1, 26);   // gap 0: back-to-back frames
        run_scn(2, 100, 0, -1, -1, -1, 10);  // single pixel, all markers

        repeat (5) @(negedge clk);
        check("rd_queue_left", 32'(rd_q.size()), 32'd0);
        check("pix_queue_left", 32'(out_q.size()), 32'd0);
        check("done_queue_left", 32'(done_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ima_stream_tx.md
Name: ima_stream_tx

Overview:
- Transmitter for the pixel-stream interface consumed by the convolution layer top.
- Reads NUM_FRAMES images of W x H 8-bit pixels, one filter dimension each, from a synchronous frame-buffer RAM.
- Emits them raster-order with the ena/frame_start/line_start/frame_end and frame_start_dim/frame_end_dim markers the conv layer expects.
- Sits between the image/feature-map buffer and the conv layer top; started by a one-cycle start pulse from the layer sequencer.

Parameters:
- IMA, 8, pixel width.
- W, 32, pixels per line.
- H, 32, lines per frame.
- NUM_FRAMES, 5, frames (dimensions) per run.
- GAP_CYC, 4, idle cycles between frame_end of one frame and frame_start of the next; 0 allowed.
- ADDR_W, 13, RAM address width; must satisfy 2^ADDR_W >= NUM_FRAMES*W*H.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  one-cycle run request; honoured only in IDLE.
- base_addr  input  ADDR_W  RAM address of pixel (0,0) of frame 0; sampled when start is honoured.
- hold  input  1  downstream stall; blocks new read issue.
- rd_en  output  1  RAM read strobe.
- rd_addr  output  ADDR_W  RAM read address.
- rd_data  input  IMA  RAM data; valid the cycle after rd_en.
- ima_out  output  IMA  pixel to conv layer.
- ena_out  output  1  ima_out valid.
- frame_start_out  output  1  with first pixel of every frame.
- line_start_out  output  1  with first pixel of every line.
- frame_end_out  output  1  with last pixel of every frame.
- frame_start_dim_out  output  1  with first pixel of frame 0 only.
- frame_end_dim_out  output  1  with last pixel of frame NUM_FRAMES-1 only.
- busy  output  1  run in progress.
- done  output  1  one-cycle run-complete pulse.

Behaviour:
- Reset (rst_n low at an edge): state IDLE, all counters 0, every output 0 (ima_out = 0), pipeline flushed. Applies mid-run: no further ena_out or markers after the reset edge; a later start begins a fresh run.
- States:
  - IDLE: start -> RUN; latch base_addr; clear col/row/frm counters.
  - RUN: issue one read per cycle when hold=0.
    - Last pixel of a non-last frame issued -> GAP, or RUN on the next frame if GAP_CYC=0.
    - Last pixel of the last frame issued -> DRAIN.
  - GAP: count GAP_CYC cycles with rd_en=0 -> RUN.
  - DRAIN: wait 2 cycles for in-flight data -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Issue rules:
  - rd_en = (state==RUN) && !hold.
  - rd_addr = base + frm*W*H + row*W + col, kept as a running address register, not a multiplier.
  - Counters advance only on an issue cycle: col wraps at W-1, then row increments; row wraps at H-1, then frm increments.
- Output pipeline, fixed latency 2:
  - Issue at cycle N; RAM returns rd_data in N+1; ima_out/ena_out registered, visible in N+2.
  - All markers ride the same 2-stage pipeline, so they are aligned with their pixel's ena_out.
  - ena_out=0 cycles carry all markers = 0; ima_out holds its last value.
- Hold: sampled only at issue. Data already issued (up to 1 pixel) is still delivered. No pixel is dropped or duplicated. hold in GAP/DRAIN has no effect.
- Marker conditions at issue:
  - line_start: col==0.
  - frame_start: col==0 && row==0.
  - frame_end: col==W-1 && row==H-1.
  - frame_start_dim: frame_start && frm==0.
  - frame_end_dim: frame_end && frm==NUM_FRAMES-1.
  - With W=1, line_start and frame_end may coincide; all may coincide for W=H=1.
- busy: 1 from the cycle after start is accepted through the DONE cycle inclusive.
- done is asserted in the cycle after frame_end_dim_out when hold=0 and GAP_CYC ignored.
- start while busy: ignored, no effect on counters.
- start and rst_n low in the same cycle: reset wins.

Test Plan:
- W=4,H=2,NUM_FRAMES=2,GAP_CYC=3, base_addr=16, RAM[a]=a, start at cycle 0, hold=0:
  - rd_addr 16..23 in cycles 1-8, then 3 idle cycles, then 24..31 in cycles 12-19.
  - ena_out/ima_out 16..23 in cycles 3-10 and 24..31 in cycles 14-21.
  - frame_start_out at cycles 3 and 14; line_start_out at 3,7,14,18; frame_end_out at 10 and 21.
  - frame_start_dim_out only at 3; frame_end_dim_out only at 21; done at 22; busy 1 in cycles 1-22.
- Same config with hold=1 for cycles 4-6:
  - No rd_en in 4-6; pixels 16,17,18 emitted in 3,4,5; ena_out=0 in 6-8; pixel 19 in cycle 9.
  - Full sequence otherwise intact, no duplicates.
- GAP_CYC=0: frame_end_out of frame 0 and frame_start_out of frame 1 in consecutive cycles (10,11).
- start pulsed again at cycle 5 mid-run: no change to addresses or timing versus the first scenario.
- rst_n low at cycle 6 mid-run: from cycle 7, all outputs 0 and busy=0. A new start at cycle 10 produces rd_addr=base_addr at cycle 11 and frame_start_dim_out at cycle 13.
- W=1,H=1,NUM_FRAMES=1: single pixel with all five markers and ena_out high in the same cycle, done one cycle later.
